// File: rtl/audio_pkg.sv
// Shared types and default constants for the audio sample scheduler.
package audio_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    COMMIT  = 3'd4
  } sched_state_t;

  // Raw ADC sample width (two's complement).
  localparam int ADC_WIDTH = 12;

  // 50 MHz / 1024 gives roughly a 48.8 kHz sample rate.
  localparam int DEFAULT_SAMPLE_DIV = 1024;

  // Longest wait for the effects pipeline result, in clk cycles.
  localparam int DEFAULT_TIMEOUT = 64;

endpackage : audio_pkg

// File: rtl/sample_tick_gen.sv
// Audio sample-rate tick generator.
// Free-running period counter 0..SAMPLE_DIV-1. The tick is combinational and
// high for exactly one cycle per period, while the counter sits on its last
// value.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign tick   = w_last;

  // Period counter: wraps to zero after the last count, restarts on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : sample_tick_gen

// File: rtl/sample_scheduler.sv
// Audio sample scheduler between the on-chip ADC and the I2S DAC stage.
// Captures one ADC sample per audio tick, hands it to the effects pipeline,
// waits (bounded) for the result and commits it to a held DAC register.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for the next sample-rate tick
//   CAPTURE | latch sign-extended ADC sample and the bypass selection
//   ISSUE   | one-cycle eff_valid strobe, arm the wait timer
//   WAIT    | wait for eff_out_valid or timer expiry
//   COMMIT  | load dac_sample; dac_update shows up the following cycle
module sample_scheduler
  import audio_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADC_WIDTH-1:0] adc_sample,
  input  logic                 bypass,
  output logic                 eff_valid,
  output logic [WIDTH-1:0]     eff_sample_in,
  input  logic                 eff_out_valid,
  input  logic [WIDTH-1:0]     eff_sample_out,
  output logic [WIDTH-1:0]     dac_sample,
  output logic                 dac_update,
  output logic                 overrun,
  output logic                 timeout_err,
  input  logic                 clr_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

  sched_state_t r_state;
  sched_state_t w_next;

  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_dac;
  logic             r_dac_update;
  logic             r_bypass;
  logic [TW-1:0]    r_wait_cnt;
  logic             r_overrun;
  logic             r_timeout_err;

  logic w_tick;
  logic w_wait_done;
  logic w_timeout_hit;
  logic w_overrun_hit;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // The wait timer counts down from TIMEOUT-1; zero is its terminal count,
  // giving exactly TIMEOUT cycles in WAIT.
  assign w_wait_done   = (r_wait_cnt == '0);
  assign w_timeout_hit = (r_state == WAIT) && !eff_out_valid && w_wait_done;
  // A tick that lands while a sample is in flight is dropped and flagged.
  assign w_overrun_hit = w_tick && (r_state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_next = CAPTURE;
      CAPTURE: w_next = bypass ? COMMIT : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (eff_out_valid || w_wait_done) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Sample, result and DAC registers plus the wait timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample     <= '0;
      r_result     <= '0;
      r_dac        <= '0;
      r_dac_update <= 1'b0;
      r_bypass     <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_dac_update <= (r_state == COMMIT);
      case (r_state)
        CAPTURE: begin
          r_sample <= WIDTH'($signed(adc_sample));
          r_bypass <= bypass;
        end
        ISSUE: begin
          r_wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (eff_out_valid) begin
            r_result <= eff_sample_out;
          end else if (w_wait_done) begin
            // No result: re-commit the value already on the DAC.
            r_result <= r_dac;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        COMMIT: begin
          r_dac <= r_bypass ? r_sample : r_result;
        end
        default: ;
      endcase
    end
  end

  // Sticky fault flags; a new fault in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_overrun     <= w_overrun_hit | (r_overrun & ~clr_err);
      r_timeout_err <= w_timeout_hit | (r_timeout_err & ~clr_err);
    end
  end

  assign eff_valid     = (r_state == ISSUE);
  assign eff_sample_in = r_sample;
  assign dac_sample    = r_dac;
  assign dac_update    = r_dac_update;
  assign overrun       = r_overrun;
  assign timeout_err   = r_timeout_err;

endmodule : sample_scheduler

// File: tb/tb_sample_scheduler.sv
// Testbench for sample_scheduler: directed and random stimulus, checked
// cycle by cycle against an event-schedule model of the sample transaction.
module tb_sample_scheduler;

  localparam int A_DIV = 32;
  localparam int A_TO  = 8;
  localparam int B_DIV = 16;
  localparam int B_TO  = 64;
  localparam int SZ    = 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_byp, a_eov, a_clr, a_ev, a_upd, a_ovr, a_tmo;
  logic [11:0] a_adc;
  logic [15:0] a_eout, a_esi, a_dac;
  logic        b_rst, b_byp, b_eov, b_clr, b_ev, b_upd, b_ovr, b_tmo;
  logic [11:0] b_adc;
  logic [15:0] b_eout, b_esi, b_dac;

  sample_scheduler #(.WIDTH(16), .SAMPLE_DIV(A_DIV), .TIMEOUT(A_TO)) u_a (
    .clk(clk), .rst(a_rst), .adc_sample(a_adc), .bypass(a_byp),
    .eff_valid(a_ev), .eff_sample_in(a_esi), .eff_out_valid(a_eov),
    .eff_sample_out(a_eout), .dac_sample(a_dac), .dac_update(a_upd),
    .overrun(a_ovr), .timeout_err(a_tmo), .clr_err(a_clr));

  sample_scheduler #(.WIDTH(16), .SAMPLE_DIV(B_DIV), .TIMEOUT(B_TO)) u_b (
    .clk(clk), .rst(b_rst), .adc_sample(b_adc), .bypass(b_byp),
    .eff_valid(b_ev), .eff_sample_in(b_esi), .eff_out_valid(b_eov),
    .eff_sample_out(b_eout), .dac_sample(b_dac), .dac_update(b_upd),
    .overrun(b_ovr), .timeout_err(b_tmo), .clr_err(b_clr));

  // Stimulus per cycle.
  logic [11:0] s_adc  [SZ];
  logic [15:0] s_eout [SZ];
  bit          s_byp  [SZ];
  bit          s_eov  [SZ];
  bit          s_clr  [SZ];
  bit          s_rst  [SZ];
  // Scheduled output events produced by the model.
  bit          v_esi [SZ];
  logic [15:0] v_esi_val [SZ];
  bit          v_dac [SZ];
  logic [15:0] v_dac_val [SZ];
  bit          v_upd [SZ];
  bit          v_ev  [SZ];
  bit          v_ovr [SZ];
  bit          v_tmo [SZ];
  // Expected and observed outputs per cycle.
  logic [15:0] e_esi [SZ], e_dac [SZ], o_esi [SZ], o_dac [SZ];
  bit          e_ev [SZ], e_upd [SZ], e_ovr [SZ], e_tmo [SZ];
  bit          o_ev [SZ], o_upd [SZ], o_ovr [SZ], o_tmo [SZ];

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] sx(input logic [11:0] a);
    return {{4{a[11]}}, a};
  endfunction

  task automatic chk(input string tag, input int c, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < SZ; c++) begin
      s_adc[c] = '0; s_eout[c] = '0; s_byp[c] = 0;
      s_eov[c] = 0;  s_clr[c] = 0;   s_rst[c] = 0;
    end
  endtask

  task automatic clear_events(input int from);
    for (int k = from; k < SZ; k++) begin
      v_esi[k] = 0; v_esi_val[k] = '0; v_dac[k] = 0; v_dac_val[k] = '0;
      v_upd[k] = 0; v_ev[k] = 0; v_ovr[k] = 0; v_tmo[k] = 0;
    end
  endtask

  // Reference: each accepted tick T schedules the whole transaction at once
  // (capture at T+1, strobe at T+2, result window T+3..T+2+to), from which
  // the visible output changes follow. A tick while a transaction is still
  // in flight only schedules an overrun flag. Reset wipes the schedule.
  task automatic model(input int n, input int div, input int to);
    int base, busy, wc;
    bit found;
    logic [15:0] dac, esi;
    bit ovr, tmo;
    clear_events(0);
    base = 0; busy = -1; dac = '0; esi = '0; ovr = 0; tmo = 0;
    for (int c = 0; c < n; c++) begin
      if (c > 0 && s_rst[c-1]) begin
        clear_events(c);
        base = c; busy = -1; dac = '0; esi = '0; ovr = 0; tmo = 0;
      end
      if (v_dac[c]) dac = v_dac_val[c];
      if (v_esi[c]) esi = v_esi_val[c];
      if (v_ovr[c]) ovr = 1; else if (c > 0 && s_clr[c-1]) ovr = 0;
      if (v_tmo[c]) tmo = 1; else if (c > 0 && s_clr[c-1]) tmo = 0;
      e_dac[c] = dac; e_esi[c] = esi; e_ovr[c] = ovr; e_tmo[c] = tmo;
      e_upd[c] = v_upd[c]; e_ev[c] = v_ev[c];
      if ((c - base) % div == div - 1) begin
        if (c > busy) begin
          v_esi[c+2] = 1; v_esi_val[c+2] = sx(s_adc[c+1]);
          if (s_byp[c+1]) begin
            v_dac[c+3] = 1; v_dac_val[c+3] = sx(s_adc[c+1]);
            v_upd[c+3] = 1; busy = c + 2;
          end else begin
            v_ev[c+2] = 1; found = 0; wc = 0;
            for (int w = c + 3; w <= c + 2 + to; w++)
              if (!found && s_eov[w]) begin found = 1; wc = w; end
            if (found) begin
              v_dac[wc+2] = 1; v_dac_val[wc+2] = s_eout[wc];
              v_upd[wc+2] = 1; busy = wc + 1;
            end else begin
              v_tmo[c+3+to] = 1; v_upd[c+4+to] = 1; busy = c + 3 + to;
            end
          end
        end else begin
          v_ovr[c+1] = 1;
        end
      end
    end
  endtask

  // Reset the chosen instance, then play n cycles: drive just after the
  // rising edge, sample on the falling edge, compare with the model.
  task automatic run(input bit inst, input int n);
    if (inst == 0) begin a_rst = 1; a_clr = 0; a_eov = 0; end
    else           begin b_rst = 1; b_clr = 0; b_eov = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < n; c++) begin
      if (inst == 0) begin
        a_rst = s_rst[c]; a_adc = s_adc[c]; a_byp = s_byp[c];
        a_eov = s_eov[c]; a_eout = s_eout[c]; a_clr = s_clr[c];
      end else begin
        b_rst = s_rst[c]; b_adc = s_adc[c]; b_byp = s_byp[c];
        b_eov = s_eov[c]; b_eout = s_eout[c]; b_clr = s_clr[c];
      end
      @(negedge clk);
      if (inst == 0) begin
        o_ev[c] = a_ev; o_esi[c] = a_esi; o_dac[c] = a_dac;
        o_upd[c] = a_upd; o_ovr[c] = a_ovr; o_tmo[c] = a_tmo;
      end else begin
        o_ev[c] = b_ev; o_esi[c] = b_esi; o_dac[c] = b_dac;
        o_upd[c] = b_upd; o_ovr[c] = b_ovr; o_tmo[c] = b_tmo;
      end
      chk("eff_valid", c, 16'(o_ev[c]), 16'(e_ev[c]));
      chk("eff_sample_in", c, o_esi[c], e_esi[c]);
      chk("dac_sample", c, o_dac[c], e_dac[c]);
      chk("dac_update", c, 16'(o_upd[c]), 16'(e_upd[c]));
      chk("overrun", c, 16'(o_ovr[c]), 16'(e_ovr[c]));
      chk("timeout_err", c, 16'(o_tmo[c]), 16'(e_tmo[c]));
      @(posedge clk);
      #1;
    end
    if (inst == 0) begin a_eov = 0; a_clr = 0; end
    else           begin b_eov = 0; b_clr = 0; end
  endtask

  initial begin
    bit any;
    a_rst = 1; a_adc = '0; a_byp = 0; a_eov = 0; a_eout = '0; a_clr = 0;
    b_rst = 1; b_adc = '0; b_byp = 0; b_eov = 0; b_eout = '0; b_clr = 0;

    // Bypass: tick at 31, committed sample visible at 34, no strobe.
    clear_stim();
    for (int c = 0; c < 40; c++) begin s_byp[c] = 1; s_adc[c] = 12'h800; end
    model(40, A_DIV, A_TO);
    run(0, 40);
    chk("byp_dac33", 33, o_dac[33], 16'h0000);
    chk("byp_dac34", 34, o_dac[34], 16'hF800);
    chk("byp_upd34", 34, 16'(o_upd[34]), 16'd1);
    chk("byp_upd35", 35, 16'(o_upd[35]), 16'd0);
    any = 0;
    for (int c = 0; c < 40; c++) any |= o_ev[c];
    chk("byp_no_eff_valid", 0, 16'(any), 16'd0);

    // Effects path: result three cycles after the strobe.
    clear_stim();
    for (int c = 0; c < 45; c++) s_adc[c] = 12'h123;
    s_eov[36] = 1; s_eout[36] = 16'h0246;
    model(45, A_DIV, A_TO);
    run(0, 45);
    chk("eff_ev33", 33, 16'(o_ev[33]), 16'd1);
    chk("eff_esi33", 33, o_esi[33], 16'h0123);
    chk("eff_dac37", 37, o_dac[37], 16'h0000);
    chk("eff_dac38", 38, o_dac[38], 16'h0246);
    chk("eff_upd38", 38, 16'(o_upd[38]), 16'd1);

    // Timeout: bypass commit first, then an unanswered request, then normal.
    clear_stim();
    for (int c = 0; c < 110; c++) begin s_adc[c] = 12'h5A5; s_byp[c] = (c < 40); end
    s_eov[99] = 1; s_eout[99] = 16'h1234;
    model(110, A_DIV, A_TO);
    run(0, 110);
    chk("to_tmo73", 73, 16'(o_tmo[73]), 16'd0);
    chk("to_tmo74", 74, 16'(o_tmo[74]), 16'd1);
    chk("to_upd75", 75, 16'(o_upd[75]), 16'd1);
    chk("to_dac75", 75, o_dac[75], 16'h05A5);
    chk("to_ev97", 97, 16'(o_ev[97]), 16'd1);
    chk("to_dac101", 101, o_dac[101], 16'h1234);

    // Reset during WAIT, with a late result that must be ignored.
    clear_stim();
    for (int c = 0; c < 80; c++) s_adc[c] = 12'h321;
    s_rst[36] = 1;
    s_eov[38] = 1; s_eout[38] = 16'hFFFF;
    model(80, A_DIV, A_TO);
    run(0, 80);
    any = 0;
    for (int c = 0; c < 80; c++) any |= o_upd[c];
    chk("rst_no_upd", 0, 16'(any), 16'd0);
    chk("rst_esi37", 37, o_esi[37], 16'h0000);
    chk("rst_ev69", 69, 16'(o_ev[69]), 16'd0);
    chk("rst_ev70", 70, 16'(o_ev[70]), 16'd1);

    // Random traffic on the nominal instance.
    clear_stim();
    for (int c = 0; c < 500; c++) begin
      s_adc[c]  = 12'($urandom);
      s_eout[c] = 16'($urandom);
      s_byp[c]  = ($urandom_range(2) == 0);
      s_eov[c]  = ($urandom_range(4) == 0);
      s_clr[c]  = ($urandom_range(16) == 0);
      s_rst[c]  = ($urandom_range(249) == 0);
    end
    model(500, A_DIV, A_TO);
    run(0, 500);

    // Overrun: period shorter than the wait; clr loses to a same-cycle fault.
    clear_stim();
    s_clr[40] = 1; s_clr[47] = 1;
    model(120, B_DIV, B_TO);
    run(1, 120);
    chk("ovr31", 31, 16'(o_ovr[31]), 16'd0);
    chk("ovr32", 32, 16'(o_ovr[32]), 16'd1);
    chk("ovr41", 41, 16'(o_ovr[41]), 16'd0);
    chk("ovr48", 48, 16'(o_ovr[48]), 16'd1);
    chk("ovr_tmo81", 81, 16'(o_tmo[81]), 16'd0);
    chk("ovr_tmo82", 82, 16'(o_tmo[82]), 16'd1);

    // Random traffic on the short-period instance.
    clear_stim();
    for (int c = 0; c < 300; c++) begin
      s_adc[c]  = 12'($urandom);
      s_eout[c] = 16'($urandom);
      s_byp[c]  = ($urandom_range(3) == 0);
      s_eov[c]  = ($urandom_range(24) == 0);
      s_clr[c]  = ($urandom_range(10) == 0);
      s_rst[c]  = ($urandom_range(199) == 0);
    end
    model(300, B_DIV, B_TO);
    run(1, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sample_scheduler

// File: doc/sample_scheduler.md
# sample_scheduler

Sequencing controller for the audio datapath between the 12-bit on-chip ADC and the I2S DAC output stage. It generates the audio sample-rate tick and captures one ADC sample per tick. It issues that sample to the effects pipeline with a single-cycle valid, waits for the pipeline result with a timeout, and commits the result (or the raw sample in bypass) to a held DAC register. Overrun and timeout faults are flagged so the output stage never sees a half-updated sample.

## Interface
Parameters:
- WIDTH, 16, datapath sample width (must be ≥ 12)
- SAMPLE_DIV, 1024, clk cycles per audio sample (50 MHz / 1024 ≈ 48.8 kHz); ≥ TIMEOUT + 8
- TIMEOUT, 64, max clk cycles spent waiting for the effects result

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- adc_sample  in  12  signed ADC sample (already converted to two's complement)
- bypass  in  1  1 = skip effects, commit captured sample directly
- eff_valid  out  1  one-cycle strobe: eff_sample_in is valid
- eff_sample_in  out  WIDTH  sign-extended captured sample, held between strobes
- eff_out_valid  in  1  effects pipeline result strobe
- eff_sample_out  in  WIDTH  effects pipeline result
- dac_sample  out  WIDTH  committed sample for the DAC stage, held between commits
- dac_update  out  1  one-cycle pulse, coincident with a new dac_sample value
- overrun  out  1  sticky: a tick arrived while not IDLE
- timeout_err  out  1  sticky: WAIT expired without eff_out_valid
- clr_err  in  1  clears overrun and timeout_err

## Operation
- Tick counter counts 0..SAMPLE_DIV-1 and wraps. tick = (count == SAMPLE_DIV-1), combinational, one cycle per period.
- FSM states: IDLE, CAPTURE, ISSUE, WAIT, COMMIT.
  - IDLE: on tick, go to CAPTURE.
  - CAPTURE: sample_reg <= sign-extend(adc_sample) to WIDTH. Go to COMMIT if bypass, else ISSUE.
  - ISSUE: eff_valid = 1 for this cycle, then WAIT. Clear the wait counter.
  - WAIT: on eff_out_valid, latch result_reg <= eff_sample_out and go to COMMIT. If the wait counter reaches TIMEOUT-1 without eff_out_valid, set timeout_err, keep result_reg = previous dac_sample, and go to COMMIT.
  - COMMIT: dac_sample <= (bypass path ? sample_reg : result_reg), and dac_update <= 1. Both become visible the next cycle. Return to IDLE.
- bypass is sampled only in CAPTURE. Changing it mid-sample has no effect until the next tick.
- eff_out_valid is ignored in every state except WAIT.
- A tick in any state other than IDLE sets overrun, and that tick is dropped. The current sample finishes normally.
- clr_err clears both sticky flags next cycle. If clr_err and a new fault occur in the same cycle, the fault wins (flag stays 1).
- eff_sample_in always drives sample_reg.

## Timing
- Reset values: state IDLE, count 0, eff_valid 0, eff_sample_in 0, dac_sample 0, dac_update 0, overrun 0, timeout_err 0, result_reg 0.
- After reset release, the first tick is at cycle SAMPLE_DIV-1.
- Tick at cycle T gives:
  - CAPTURE at T+1
  - eff_valid high at T+2
  - WAIT from T+3
- Bypass latency: COMMIT at T+2, dac_sample/dac_update visible at T+3.
- Effects path: eff_out_valid first seen at cycle W ≥ T+3 → COMMIT at W+1 → visible at W+2.
- Timeout path: WAIT spans T+3..T+2+TIMEOUT, COMMIT at T+3+TIMEOUT, timeout_err set at T+3+TIMEOUT.
- rst mid-operation aborts the current sample immediately, with no dac_update. The counter restarts from 0.

## Structure
- Package audio_pkg holds:
  - typedef enum sched_state_t {IDLE, CAPTURE, ISSUE, WAIT, COMMIT}
  - ADC_WIDTH = 12
  - the default SAMPLE_DIV/TIMEOUT constants
- One sub-module, sample_tick_gen (parameter SAMPLE_DIV; ports clk, rst, tick), owns the period counter. The FSM, wait counter and output registers live in sample_scheduler.

## Test plan
- SAMPLE_DIV=32, bypass=1, adc_sample=12'h800 → at cycle 34: dac_sample=16'hF800, dac_update high one cycle, eff_valid never asserted.
- bypass=0, adc_sample=12'h123, stub pipeline returns eff_sample_out=16'h0246 three cycles after eff_valid → eff_sample_in=16'h0123 at eff_valid, dac_sample=16'h0246 two cycles after eff_out_valid.
- bypass=0, pipeline never responds, TIMEOUT=8 → timeout_err=1 at T+11, dac_update pulses with dac_sample unchanged, next tick processes normally.
- SAMPLE_DIV=16, TIMEOUT=64, no response → overrun=1 at the second tick, that tick dropped. Then clr_err pulse → overrun=0 next cycle.
- rst asserted during WAIT, then eff_out_valid pulses → no dac_update, all outputs 0, first new eff_valid at SAMPLE_DIV+1 after release.
